// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   // Branch targets are forced onto a word boundary.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, decode-handshake and redirect bundle for fetch_sequencer.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_data;
   logic [INST_W-1:0] inst_out;
   logic [ADDR_W-1:0] pc_out;
   logic              inst_valid;
   logic              inst_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output rom_addr, inst_out, pc_out, inst_valid,
      input  rom_data, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  rom_addr, inst_out, pc_out, inst_valid,
      output rom_data, inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register between fetch and decode.
module fetch_out_reg
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              hold,
   input  logic              flush,
   input  logic [INST_W-1:0] d_inst,
   input  logic [ADDR_W-1:0] d_pc,
   output logic [INST_W-1:0] inst_q,
   output logic [ADDR_W-1:0] pc_q,
   output logic              valid_q
);

   // flush beats load beats hold; with none of them the entry empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_q  <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         inst_q  <= d_inst;
         pc_q    <= d_pc;
         valid_q <= 1'b1;
      end else if (!hold) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, ROM addressing, output stage, redirects.
// Optional macro FETCH_HALT_ON_ZERO_EN stops fetch on an all-zero ROM word.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
   parameter logic [ADDR_W-1:0] PC_LIMIT = 32'd20,
   parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               halted,
   fetch_sequencer_if.master  fif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_d;
   logic              load, hold, flush;
   logic              xfer_c, slot_free_c, zero_word_c;

   assign fif.rom_addr = pc_q;
   assign xfer_c       = fif.inst_valid & fif.inst_ready;
   assign slot_free_c  = ~fif.inst_valid | xfer_c;

`ifdef FETCH_HALT_ON_ZERO_EN
   assign zero_word_c = (fif.rom_data == INST_W'(0));
`else
   assign zero_word_c = 1'b0;
`endif

   // Next state, next PC and output-stage controls.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      hold    = fif.inst_valid & ~fif.inst_ready;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         RUN: begin
            if (fif.redirect_valid) begin
               flush = 1'b1;
               pc_d  = align_pc(fif.redirect_pc);
            end else if (zero_word_c) begin
               state_d = slot_free_c ? HALT : DRAIN;
            end else if (slot_free_c) begin
               load = 1'b1;
               if (pc_q == PC_LIMIT) state_d = DRAIN;
               else                  pc_d    = pc_q + PC_STEP;
            end
         end
         DRAIN: begin
            if (fif.redirect_valid) begin
               flush   = 1'b1;
               pc_d    = align_pc(fif.redirect_pc);
               state_d = RUN;
            end else if (slot_free_c) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         default: state_d = IDLE;
      endcase
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         halted  <= halted_d;
      end
   end

   fetch_out_reg u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .hold    (hold),
      .flush   (flush),
      .d_inst  (fif.rom_data),
      .d_pc    (pc_q),
      .inst_q  (fif.inst_out),
      .pc_q    (fif.pc_out),
      .valid_q (fif.inst_valid)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a six-word ROM model.
module tb_fetch_sequencer;

`ifdef FETCH_HALT_ON_ZERO_EN
   localparam logic [31:0] LIMIT = 32'd40;
`else
   localparam logic [31:0] LIMIT = 32'd20;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic halted;
   int   total = 0;
   int   bad   = 0;

   fetch_sequencer_if fif ();

   fetch_sequencer #(
      .RESET_PC (32'd0),
      .PC_LIMIT (LIMIT),
      .PC_STEP  (32'd4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .halted (halted),
      .fif    (fif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h913E_8021;
         32'd4:   return 32'h913E_8042;
         32'd8:   return 32'h913E_8063;
         32'd12:  return 32'h913E_8084;
         32'd16:  return 32'h913E_80A5;
         32'd20:  return 32'hF280_0282;
         default: return 32'h0000_0000;
      endcase
   endfunction

   always_comb fif.rom_data = rom_word(fif.rom_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ready held high: one word per cycle from first_pc to last_pc.
   task automatic stream(input logic [31:0] first_pc, input logic [31:0] last_pc);
      for (logic [31:0] e = first_pc; e <= last_pc; e += 32'd4) begin
         tick();
         chk("stream_valid", 32'(fif.inst_valid), 32'd1);
         chk("stream_pc", fif.pc_out, e);
         chk("stream_inst", fif.inst_out, rom_word(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      fif.inst_ready     = 1'b0;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc    = 32'd0;
      tick();
      tick();
      chk("rst_valid", 32'(fif.inst_valid), 32'd0);
      chk("rst_addr", fif.rom_addr, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_inst", fif.inst_out, 32'd0);
      chk("rst_pc_out", fif.pc_out, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_no_fetch", 32'(fif.inst_valid), 32'd0);

      // Straight run from start.
      fif.inst_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_first_empty", 32'(fif.inst_valid), 32'd0);
      stream(32'd0, 32'd20);

`ifdef FETCH_HALT_ON_ZERO_EN
      chk("zero_addr24", fif.rom_addr, 32'd24);
      tick();
      chk("zero_halted", 32'(halted), 32'd1);
      chk("zero_not_presented", 32'(fif.inst_valid), 32'd0);
      chk("zero_addr_hold", fif.rom_addr, 32'd24);
`else
      chk("drain_addr", fif.rom_addr, 32'd20);
      chk("drain_not_halted", 32'(halted), 32'd0);
      tick();
      chk("halt_after_last", 32'(halted), 32'd1);
      chk("halt_valid", 32'(fif.inst_valid), 32'd0);
      chk("halt_addr", fif.rom_addr, 32'd20);
      tick();
      chk("halt_addr_stay", fif.rom_addr, 32'd20);

      // Restart from HALT, then backpressure on the first word.
      fif.inst_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_addr", fif.rom_addr, 32'd0);
      chk("restart_halted", 32'(halted), 32'd0);
      tick();
      chk("restart_pc_out", fif.pc_out, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", 32'(fif.inst_valid), 32'd1);
         chk("bp_inst", fif.inst_out, 32'h913E_8021);
         chk("bp_pc_out", fif.pc_out, 32'd0);
         chk("bp_addr", fif.rom_addr, 32'd4);
      end
      fif.inst_ready = 1'b1;
      stream(32'd4, 32'd8);
      chk("pre_stall_addr", fif.rom_addr, 32'd12);

      // Redirect to an unaligned target while pc_out=8 is stalled.
      fif.inst_ready = 1'b0;
      tick();
      chk("stall8_pc_out", fif.pc_out, 32'd8);
      fif.redirect_valid = 1'b1;
      fif.redirect_pc    = 32'h0000_000E;
      tick();
      fif.redirect_valid = 1'b0;
      chk("redir_squash", 32'(fif.inst_valid), 32'd0);
      chk("redir_aligned", fif.rom_addr, 32'h0000_000C);
      fif.inst_ready = 1'b1;
      stream(32'd12, 32'd20);

      // Redirect during DRAIN with the last word stalled.
      fif.inst_ready     = 1'b0;
      fif.redirect_valid = 1'b1;
      fif.redirect_pc    = 32'd4;
      tick();
      fif.redirect_valid = 1'b0;
      chk("drain_redir_valid", 32'(fif.inst_valid), 32'd0);
      chk("drain_redir_addr", fif.rom_addr, 32'd4);
      chk("drain_redir_halted", 32'(halted), 32'd0);
      fif.inst_ready = 1'b1;
      stream(32'd4, 32'd20);
      tick();
      chk("drain_redir_halt", 32'(halted), 32'd1);
      chk("drain_redir_empty", 32'(fif.inst_valid), 32'd0);

      // Asynchronous reset between edges while a word is held.
      start = 1'b1;
      tick();
      start = 1'b0;
      stream(32'd0, 32'd4);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(fif.inst_valid), 32'd0);
      chk("arst_addr", fif.rom_addr, 32'd0);
      chk("arst_halted", 32'(halted), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      chk("arst_idle_valid", 32'(fif.inst_valid), 32'd0);
      chk("arst_idle_addr", fif.rom_addr, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      stream(32'd0, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
